// File: rtl/ioexp_input_tracker_if.sv
// Read-side bus from i2c_master plus the polling FSM's capture qualifiers.
// Polling FSM/i2c_master drive (master); the tracker only observes (slave).
interface ioexp_input_tracker_if;
  logic       i2c_busy;
  logic [7:0] i2c_rdata;
  logic       i2c_error;
  logic       rd_capture;
  logic       rd_byte_sel;
  logic       poll_done;

  modport master (
    output i2c_busy, i2c_rdata, i2c_error, rd_capture, rd_byte_sel, poll_done
  );
  modport slave (
    input  i2c_busy, i2c_rdata, i2c_error, rd_capture, rd_byte_sel, poll_done
  );
endinterface

// File: rtl/ioexp_input_tracker.sv
// Collects the two I/O-expander port bytes of each poll, debounces every bit over
// consecutive committed polls and reports stable levels, change flags, irq and stats.
module ioexp_input_tracker #(
  parameter int DEBOUNCE_POLLS = 3,
  parameter int CNT_W          = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  ioexp_input_tracker_if.slave   bus,
  input  logic [15:0]            clear_bits,
  input  logic [15:0]            irq_mask,
  output logic [15:0]            stable_out,
  output logic                   valid,
  output logic                   change_pulse,
  output logic [15:0]            changed_bits,
  output logic                   irq,
  output logic [7:0]             sample_count,
  output logic [7:0]             error_count
);

  localparam logic [CNT_W-1:0] DEB = DEBOUNCE_POLLS[CNT_W-1:0];

  // Transfer framing: busy rising marks the start of a byte and is when the FSM's
  // rd_capture/rd_byte_sel are valid; busy falling marks data_rd/ack_error valid.
  logic            busy_last;
  logic            tag_rd;
  logic            tag_sel;
  logic [1:0]      got_mask;
  logic            poll_err;
  logic [7:0]      shadow0;
  logic [7:0]      shadow1;
  logic [CNT_W-1:0] cnt [16];

  logic            rise;
  logic            fall;
  logic [1:0]      got_mask_nxt;
  logic            poll_err_nxt;
  logic [7:0]      shadow0_nxt;
  logic [7:0]      shadow1_nxt;
  logic            commit;
  logic            reject;
  logic [15:0]     sample;
  logic [15:0]     flip;
  logic [15:0]     stable_nxt;
  logic [CNT_W-1:0] cnt_nxt [16];

  always_comb begin
    rise         = bus.i2c_busy & ~busy_last;
    fall         = ~bus.i2c_busy & busy_last;
    got_mask_nxt = got_mask;
    poll_err_nxt = poll_err;
    shadow0_nxt  = shadow0;
    shadow1_nxt  = shadow1;
    if (fall && tag_rd) begin
      if (bus.i2c_error) begin
        poll_err_nxt = 1'b1;
      end else if (tag_sel) begin
        shadow1_nxt     = bus.i2c_rdata;
        got_mask_nxt[1] = 1'b1;
      end else begin
        shadow0_nxt     = bus.i2c_rdata;
        got_mask_nxt[0] = 1'b1;
      end
    end
    // A byte finishing in the poll_done cycle still counts toward this poll.
    commit = bus.poll_done && (got_mask_nxt == 2'b11) && !poll_err_nxt;
    reject = bus.poll_done && !commit;
    sample = {shadow1_nxt, shadow0_nxt};
  end

  always_comb begin
    flip       = '0;
    stable_nxt = stable_out;
    for (int b = 0; b < 16; b++) cnt_nxt[b] = cnt[b];
    if (commit) begin
      if (!valid) begin
        stable_nxt = sample;
        for (int b = 0; b < 16; b++) cnt_nxt[b] = '0;
      end else begin
        for (int b = 0; b < 16; b++) begin
          if (sample[b] == stable_out[b]) begin
            cnt_nxt[b] = '0;
          end else if ((cnt[b] + 1'b1) == DEB) begin
            stable_nxt[b] = ~stable_out[b];
            cnt_nxt[b]    = '0;
            flip[b]       = 1'b1;
          end else begin
            cnt_nxt[b] = cnt[b] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_last    <= 1'b0;
      tag_rd       <= 1'b0;
      tag_sel      <= 1'b0;
      got_mask     <= 2'b00;
      poll_err     <= 1'b0;
      shadow0      <= '0;
      shadow1      <= '0;
      stable_out   <= '0;
      valid        <= 1'b0;
      change_pulse <= 1'b0;
      changed_bits <= '0;
      sample_count <= '0;
      error_count  <= '0;
      for (int b = 0; b < 16; b++) cnt[b] <= '0;
    end else begin
      busy_last <= bus.i2c_busy;
      if (rise) begin
        tag_rd  <= bus.rd_capture;
        tag_sel <= bus.rd_byte_sel;
      end
      shadow0      <= shadow0_nxt;
      shadow1      <= shadow1_nxt;
      got_mask     <= bus.poll_done ? 2'b00 : got_mask_nxt;
      poll_err     <= bus.poll_done ? 1'b0  : poll_err_nxt;
      stable_out   <= stable_nxt;
      change_pulse <= |flip;
      changed_bits <= (changed_bits & ~clear_bits) | flip;
      for (int b = 0; b < 16; b++) cnt[b] <= cnt_nxt[b];
      if (commit) begin
        valid        <= 1'b1;
        sample_count <= sample_count + 8'd1;
      end
      if (reject && (error_count != 8'hFF)) error_count <= error_count + 8'd1;
    end
  end

  assign irq = |(changed_bits & irq_mask);

endmodule

// File: tb/tb_ioexp_input_tracker.sv
// Directed bench for ioexp_input_tracker: byte framing, commit/reject, debounce,
// sticky flags and counters, with hand-computed expectations.
module tb_ioexp_input_tracker;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] clear_bits;
  logic [15:0] irq_mask;
  logic [15:0] stable_out;
  logic        valid;
  logic        change_pulse;
  logic [15:0] changed_bits;
  logic        irq;
  logic [7:0]  sample_count;
  logic [7:0]  error_count;

  int n_cmp = 0;
  int n_err = 0;

  ioexp_input_tracker_if bus_if ();

  ioexp_input_tracker #(.DEBOUNCE_POLLS(3), .CNT_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus_if.slave),
    .clear_bits   (clear_bits),
    .irq_mask     (irq_mask),
    .stable_out   (stable_out),
    .valid        (valid),
    .change_pulse (change_pulse),
    .changed_bits (changed_bits),
    .irq          (irq),
    .sample_count (sample_count),
    .error_count  (error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One byte transfer: busy high for two cycles; data/error valid at the fall.
  task automatic xfer(input logic rd, input logic sel, input logic [7:0] data, input logic err);
    @(negedge clk);
    bus_if.i2c_busy    = 1'b1;
    bus_if.rd_capture  = rd;
    bus_if.rd_byte_sel = sel;
    @(negedge clk);
    bus_if.rd_capture  = 1'b0;
    bus_if.rd_byte_sel = 1'b0;
    bus_if.i2c_rdata   = data;
    bus_if.i2c_error   = err;
    @(negedge clk);
    bus_if.i2c_busy    = 1'b0;
    @(negedge clk);
    bus_if.i2c_error   = 1'b0;
  endtask

  // Ends at the negedge right after the poll_done edge, where results are visible.
  task automatic poll_pulse(input logic [15:0] clr);
    @(negedge clk);
    bus_if.poll_done = 1'b1;
    clear_bits       = clr;
    @(negedge clk);
    bus_if.poll_done = 1'b0;
    clear_bits       = '0;
  endtask

  task automatic poll(input logic [7:0] p0, input logic [7:0] p1, input logic [15:0] clr);
    xfer(1'b1, 1'b0, p0, 1'b0);
    xfer(1'b1, 1'b1, p1, 1'b0);
    poll_pulse(clr);
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    bus_if.i2c_busy  = 1'b1;
    repeat (3) @(negedge clk);
    reset_n          = 1'b1;
    @(negedge clk);
    bus_if.i2c_busy  = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n            = 1'b0;
    clear_bits         = '0;
    irq_mask           = '0;
    bus_if.i2c_busy    = 1'b0;
    bus_if.i2c_rdata   = '0;
    bus_if.i2c_error   = 1'b0;
    bus_if.rd_capture  = 1'b0;
    bus_if.rd_byte_sel = 1'b0;
    bus_if.poll_done   = 1'b0;

    // Reset with a stale busy that falls afterwards: must be ignored.
    do_reset();
    check("rst_stable", stable_out, 16'h0000);
    check("rst_valid", {15'd0, valid}, 16'd0);
    check("rst_changed", changed_bits, 16'h0000);
    check("rst_samples", {8'd0, sample_count}, 16'd0);
    check("rst_errors", {8'd0, error_count}, 16'd0);

    // First commit reloads without a pulse.
    poll(8'h5A, 8'hC3, 16'h0);
    check("first_stable", stable_out, 16'hC35A);
    check("first_valid", {15'd0, valid}, 16'd1);
    check("first_pulse", {15'd0, change_pulse}, 16'd0);
    check("first_samples", {8'd0, sample_count}, 16'd1);
    check("first_changed", changed_bits, 16'h0000);

    // Bit0 flips only on the third consecutive differing sample.
    poll(8'h5B, 8'hC3, 16'h0);
    check("deb1_stable", stable_out, 16'hC35A);
    poll(8'h5B, 8'hC3, 16'h0);
    check("deb2_stable", stable_out, 16'hC35A);
    check("deb2_pulse", {15'd0, change_pulse}, 16'd0);
    poll(8'h5B, 8'hC3, 16'h0);
    check("deb3_stable", stable_out, 16'hC35B);
    check("deb3_pulse", {15'd0, change_pulse}, 16'd1);
    check("deb3_changed", changed_bits, 16'h0001);
    @(negedge clk);
    check("deb3_pulse_end", {15'd0, change_pulse}, 16'd0);
    irq_mask = 16'h0001;
    #1 check("irq_on", {15'd0, irq}, 16'd1);
    irq_mask = 16'h0000;
    #1 check("irq_off", {15'd0, irq}, 16'd0);
    irq_mask = 16'h0001;
    check("deb_samples", {8'd0, sample_count}, 16'd4);

    // Alternating samples: a match resets the counter, so no flip.
    poll(8'h5A, 8'hC3, 16'h0);
    poll(8'h5B, 8'hC3, 16'h0);
    poll(8'h5A, 8'hC3, 16'h0);
    poll(8'h5A, 8'hC3, 16'h0);
    check("alt_stable", stable_out, 16'hC35B);
    check("alt_pulse", {15'd0, change_pulse}, 16'd0);
    check("alt_samples", {8'd0, sample_count}, 16'd8);

    // Port 1 byte NAKed: rejected.
    xfer(1'b1, 1'b0, 8'h5A, 1'b0);
    xfer(1'b1, 1'b1, 8'hC3, 1'b1);
    poll_pulse(16'h0);
    check("err_count", {8'd0, error_count}, 16'd1);
    check("err_samples", {8'd0, sample_count}, 16'd8);
    check("err_stable", stable_out, 16'hC35B);

    // Only port 0 captured: rejected.
    xfer(1'b1, 1'b0, 8'h5B, 1'b0);
    poll_pulse(16'h0);
    check("half_errors", {8'd0, error_count}, 16'd2);
    check("half_samples", {8'd0, sample_count}, 16'd8);

    // A write byte in between is not captured.
    xfer(1'b1, 1'b0, 8'h5B, 1'b0);
    xfer(1'b0, 1'b1, 8'hFF, 1'b0);
    xfer(1'b1, 1'b1, 8'hC3, 1'b0);
    poll_pulse(16'h0);
    check("wr_ignored_stable", stable_out, 16'hC35B);
    check("wr_ignored_samples", {8'd0, sample_count}, 16'd9);

    // Busy fall coincident with poll_done completes the poll.
    xfer(1'b1, 1'b0, 8'h5B, 1'b0);
    @(negedge clk);
    bus_if.i2c_busy    = 1'b1;
    bus_if.rd_capture  = 1'b1;
    bus_if.rd_byte_sel = 1'b1;
    @(negedge clk);
    bus_if.rd_capture  = 1'b0;
    bus_if.rd_byte_sel = 1'b0;
    bus_if.i2c_rdata   = 8'hC3;
    @(negedge clk);
    bus_if.i2c_busy    = 1'b0;
    bus_if.poll_done   = 1'b1;
    @(negedge clk);
    bus_if.poll_done   = 1'b0;
    check("coinc_samples", {8'd0, sample_count}, 16'd10);
    check("coinc_errors", {8'd0, error_count}, 16'd2);

    // Set wins over a same-cycle clear; then a lone clear takes effect.
    poll(8'h5A, 8'hC3, 16'h0);
    poll(8'h5A, 8'hC3, 16'h0);
    poll(8'h5A, 8'hC3, 16'h0001);
    check("clr_race_stable", stable_out, 16'hC35A);
    check("clr_race_pulse", {15'd0, change_pulse}, 16'd1);
    check("clr_race_changed", changed_bits, 16'h0001);
    clear_bits = 16'h0001;
    @(negedge clk);
    clear_bits = 16'h0000;
    check("clr_alone_changed", changed_bits, 16'h0000);
    check("clr_alone_irq", {15'd0, irq}, 16'd0);

    // sample_count wraps at 256 commits (13 so far).
    for (int i = 0; i < 243; i++) poll(8'h5A, 8'hC3, 16'h0);
    check("wrap_samples", {8'd0, sample_count}, 16'd0);
    check("wrap_stable", stable_out, 16'hC35A);

    // error_count saturates.
    for (int i = 0; i < 300; i++) poll_pulse(16'h0);
    check("sat_errors", {8'd0, error_count}, 16'd255);
    check("sat_stable", stable_out, 16'hC35A);

    // Reset mid-poll discards the partial byte; next commit reloads silently.
    xfer(1'b1, 1'b0, 8'h11, 1'b0);
    do_reset();
    check("rst2_errors", {8'd0, error_count}, 16'd0);
    xfer(1'b1, 1'b1, 8'hFF, 1'b0);
    poll_pulse(16'h0);
    check("rst2_partial_rejected", {8'd0, error_count}, 16'd1);
    poll(8'h00, 8'hFF, 16'h0);
    check("reload_stable", stable_out, 16'hFF00);
    check("reload_pulse", {15'd0, change_pulse}, 16'd0);
    check("reload_samples", {8'd0, sample_count}, 16'd1);
    check("reload_changed", changed_bits, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
